pram_uart_loader: RTL and testbench



---
 rtl/pram_uart_loader_if.sv | 10 +
 rtl/pram_uart_loader.sv | 199 +++++++++++++++++++
 tb/tb_pram_uart_loader.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/pram_uart_loader_if.sv
// Write port bundle from the UART program loader into p_ram.
// The loader drives it through the master modport; p_ram, or a bench, observes it through slave.
interface pram_uart_loader_if;
    logic [14:0] pram_address;
    logic [15:0] pram_data;
    logic        pram_wren;

    modport master (output pram_address, output pram_data, output pram_wren);
    modport slave  (input  pram_address, input  pram_data, input  pram_wren);
endinterface

// File: rtl/pram_uart_loader.sv
// Receives a checksummed program image over an 8N1 UART line and writes
// 16-bit words into p_ram, reporting busy/done/error and the word count.
module pram_uart_loader #(
    parameter int CLKS_PER_BIT = 434,
    parameter int GAP_TIMEOUT  = 65535
) (
    input  logic                       clk_in,
    input  logic                       init_n,
    input  logic                       uart_rx,
    pram_uart_loader_if.master         pram,
    output logic                       busy,
    output logic                       done,
    output logic                       error,
    output logic [15:0]                words_loaded
);

    localparam int HALF_BIT = CLKS_PER_BIT / 2;
    localparam int CW       = $clog2(CLKS_PER_BIT + 1);
    localparam int GW       = $clog2(GAP_TIMEOUT + 1) + 1;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {SYNC, ADDR_LO, ADDR_HI, CNT_LO, CNT_HI,
                              DATA_LO, DATA_HI, CHK} ld_state_t;

    rx_state_t   r_rx_state;
    logic        r_rx_meta, r_rx_sync, r_rx_prev;
    logic [CW-1:0] r_bit_clk;
    logic [2:0]  r_bit_idx;
    logic [7:0]  r_shift;
    logic        r_byte_valid, r_frame_err;

    ld_state_t   r_ld_state;
    logic [14:0] r_start;
    logic [15:0] r_count, r_idx, r_words;
    logic [7:0]  r_chk, r_lo;
    logic [GW-1:0] r_gap;
    logic [14:0] r_addr_out;
    logic [15:0] r_data_out;
    logic        r_wren, r_busy, r_done, r_error;
    logic        w_abort;
    logic [15:0] w_idx_next;

    // UART receiver: reset leaves the synchronizer at idle-high so no false start is seen
    always_ff @(posedge clk_in or negedge init_n) begin
        if (!init_n) begin
            r_rx_meta    <= 1'b1;
            r_rx_sync    <= 1'b1;
            r_rx_prev    <= 1'b1;
            r_rx_state   <= RX_IDLE;
            r_bit_clk    <= '0;
            r_bit_idx    <= 3'd0;
            r_shift      <= 8'h00;
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_rx_meta    <= uart_rx;
            r_rx_sync    <= r_rx_meta;
            r_rx_prev    <= r_rx_sync;
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            case (r_rx_state)
                RX_IDLE: begin
                    if (r_rx_prev && !r_rx_sync) begin
                        r_rx_state <= RX_START;
                        r_bit_clk  <= '0;
                    end
                end
                RX_START: begin
                    if (r_bit_clk == CW'(HALF_BIT - 1)) begin
                        r_bit_clk <= '0;
                        r_bit_idx <= 3'd0;
                        r_rx_state <= r_rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        r_bit_clk <= r_bit_clk + CW'(1);
                    end
                end
                RX_DATA: begin
                    if (r_bit_clk == CW'(CLKS_PER_BIT - 1)) begin
                        r_bit_clk <= '0;
                        r_shift   <= {r_rx_sync, r_shift[7:1]};
                        if (r_bit_idx == 3'd7) begin
                            r_rx_state <= RX_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_bit_clk <= r_bit_clk + CW'(1);
                    end
                end
                RX_STOP: begin
                    if (r_bit_clk == CW'(CLKS_PER_BIT - 1)) begin
                        r_bit_clk    <= '0;
                        r_rx_state   <= RX_IDLE;
                        r_byte_valid <= r_rx_sync;
                        r_frame_err  <= !r_rx_sync;
                    end else begin
                        r_bit_clk <= r_bit_clk + CW'(1);
                    end
                end
                default: r_rx_state <= RX_IDLE;
            endcase
        end
    end

    assign w_abort    = (r_ld_state != SYNC) &&
                        (r_frame_err || (!r_byte_valid && r_gap == GW'(GAP_TIMEOUT)));
    assign w_idx_next = r_idx + 16'd1;

    // Frame parser: one byte per state, checksum over everything after the header
    always_ff @(posedge clk_in or negedge init_n) begin
        if (!init_n) begin
            r_ld_state <= SYNC;
            r_start    <= 15'd0;
            r_count    <= 16'd0;
            r_idx      <= 16'd0;
            r_words    <= 16'd0;
            r_chk      <= 8'h00;
            r_lo       <= 8'h00;
            r_gap      <= '0;
            r_addr_out <= 15'd0;
            r_data_out <= 16'd0;
            r_wren     <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_wren <= 1'b0;
            r_gap  <= (r_ld_state == SYNC || r_byte_valid) ? '0 : r_gap + GW'(1);
            if (w_abort) begin
                r_error    <= 1'b1;
                r_busy     <= 1'b0;
                r_ld_state <= SYNC;
            end else if (r_byte_valid) begin
                if (r_ld_state != SYNC) begin
                    r_chk <= r_chk ^ r_shift;
                end
                case (r_ld_state)
                    SYNC: begin
                        if (r_shift == 8'hA5) begin
                            r_busy     <= 1'b1;
                            r_done     <= 1'b0;
                            r_error    <= 1'b0;
                            r_words    <= 16'd0;
                            r_chk      <= 8'h00;
                            r_idx      <= 16'd0;
                            r_ld_state <= ADDR_LO;
                        end
                    end
                    ADDR_LO: begin
                        r_start[7:0] <= r_shift;
                        r_ld_state   <= ADDR_HI;
                    end
                    ADDR_HI: begin
                        r_start[14:8] <= r_shift[6:0];
                        r_ld_state    <= CNT_LO;
                    end
                    CNT_LO: begin
                        r_count[7:0] <= r_shift;
                        r_ld_state   <= CNT_HI;
                    end
                    CNT_HI: begin
                        r_count[15:8] <= r_shift;
                        r_ld_state    <= ({r_shift, r_count[7:0]} == 16'd0) ? CHK : DATA_LO;
                    end
                    DATA_LO: begin
                        r_lo       <= r_shift;
                        r_ld_state <= DATA_HI;
                    end
                    DATA_HI: begin
                        r_wren     <= 1'b1;
                        r_addr_out <= r_start + r_idx[14:0];
                        r_data_out <= {r_shift, r_lo};
                        r_idx      <= w_idx_next;
                        r_words    <= r_words + 16'd1;
                        r_ld_state <= (w_idx_next == r_count) ? CHK : DATA_LO;
                    end
                    CHK: begin
                        r_done     <= (r_shift == r_chk);
                        r_error    <= (r_shift != r_chk);
                        r_busy     <= 1'b0;
                        r_ld_state <= SYNC;
                    end
                    default: r_ld_state <= SYNC;
                endcase
            end else begin
                r_ld_state <= r_ld_state;
            end
        end
    end

    assign pram.pram_address = r_addr_out;
    assign pram.pram_data    = r_data_out;
    assign pram.pram_wren    = r_wren;
    assign busy              = r_busy;
    assign done              = r_done;
    assign error             = r_error;
    assign words_loaded      = r_words;

endmodule

// File: tb/tb_pram_uart_loader.sv
// Directed bench for pram_uart_loader with an 8-clock bit period and a 200-clock gap timeout.
module tb_pram_uart_loader;

    logic        clk = 1'b0;
    logic        init_n;
    logic        uart_rx;
    logic        busy, done, error;
    logic [15:0] words_loaded;

    pram_uart_loader_if u_if ();

    pram_uart_loader #(.CLKS_PER_BIT(8), .GAP_TIMEOUT(200)) dut (
        .clk_in       (clk),
        .init_n       (init_n),
        .uart_rx      (uart_rx),
        .pram         (u_if.master),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          errors   = 0;
    int          wr_total = 0;
    int          wide_cnt = 0;
    logic        prev_wren = 1'b0;
    logic [14:0] wr_addr [64];
    logic [15:0] wr_data [64];
    logic [7:0]  tx_q [$];
    int          base;

    // Write logger: records every strobe and counts strobes longer than one clock
    always @(negedge clk) begin
        if (u_if.pram_wren) begin
            wr_addr[wr_total % 64] <= u_if.pram_address;
            wr_data[wr_total % 64] <= u_if.pram_data;
            wr_total <= wr_total + 1;
            if (prev_wren) wide_cnt <= wide_cnt + 1;
        end
        prev_wren <= u_if.pram_wren;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        uart_rx = 1'b0;
        tick(8);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            tick(8);
        end
        uart_rx = stop;
        tick(8);
        uart_rx = 1'b1;
        tick(4);
    endtask

    task automatic send_q();
        while (tx_q.size() > 0) send_byte(tx_q.pop_front(), 1'b1);
    endtask

    task automatic expect_status(input string t, input logic d, input logic e, input logic [15:0] w);
        check_eq({t, "_done"},  {31'd0, done},  {31'd0, d});
        check_eq({t, "_error"}, {31'd0, error}, {31'd0, e});
        check_eq({t, "_busy"},  {31'd0, busy},  32'd0);
        check_eq({t, "_words"}, {16'd0, words_loaded}, {16'd0, w});
    endtask

    task automatic expect_writes(input string t, input int b, input logic [14:0] a0,
                                 input logic [15:0] d0, input logic [14:0] a1, input logic [15:0] d1);
        check_eq({t, "_nwr"}, wr_total - b, 32'd2);
        check_eq({t, "_a0"}, {17'd0, wr_addr[b % 64]}, {17'd0, a0});
        check_eq({t, "_d0"}, {16'd0, wr_data[b % 64]}, {16'd0, d0});
        check_eq({t, "_a1"}, {17'd0, wr_addr[(b + 1) % 64]}, {17'd0, a1});
        check_eq({t, "_d1"}, {16'd0, wr_data[(b + 1) % 64]}, {16'd0, d1});
    endtask

    // Reference frame; 0x52 is the XOR of the eight bytes after the header
    task automatic good_frame(input string t);
        base = wr_total;
        tx_q = '{8'hA5, 8'h10, 8'h00, 8'h02, 8'h00, 8'h34, 8'h12, 8'hCD, 8'hAB, 8'h52};
        send_q();
        tick(20);
        expect_writes(t, base, 15'h0010, 16'h1234, 15'h0011, 16'hABCD);
        expect_status(t, 1'b1, 1'b0, 16'd2);
    endtask

    initial begin
        init_n  = 1'b0;
        uart_rx = 1'b1;
        tick(3);
        check_eq("rst_busy",  {31'd0, busy},  32'd0);
        check_eq("rst_done",  {31'd0, done},  32'd0);
        check_eq("rst_error", {31'd0, error}, 32'd0);
        check_eq("rst_words", {16'd0, words_loaded}, 32'd0);
        check_eq("rst_addr",  {17'd0, u_if.pram_address}, 32'd0);
        check_eq("rst_data",  {16'd0, u_if.pram_data}, 32'd0);
        init_n = 1'b1;
        base = wr_total;
        tick(1000);
        check_eq("idle_nwr", wr_total - base, 32'd0);

        // Junk ahead of the header is discarded
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        tx_q = '{8'hA5, 8'h10};
        send_q();
        check_eq("mid_busy", {31'd0, busy}, 32'd1);
        base = wr_total;
        tx_q = '{8'h00, 8'h02, 8'h00, 8'h34, 8'h12, 8'hCD, 8'hAB, 8'h52};
        send_q();
        tick(20);
        expect_writes("good", base, 15'h0010, 16'h1234, 15'h0011, 16'hABCD);
        expect_status("good", 1'b1, 1'b0, 16'd2);

        // Bad checksum: both writes still land
        base = wr_total;
        tx_q = '{8'hA5, 8'h10, 8'h00, 8'h02, 8'h00, 8'h34, 8'h12, 8'hCD, 8'hAB, 8'h00};
        send_q();
        tick(20);
        expect_writes("badchk", base, 15'h0010, 16'h1234, 15'h0011, 16'hABCD);
        expect_status("badchk", 1'b0, 1'b1, 16'd2);
        good_frame("after_bad");

        // Address wrap at the top of the 15-bit space; checksum 0x82
        base = wr_total;
        tx_q = '{8'hA5, 8'hFF, 8'h7F, 8'h02, 8'h00, 8'h11, 8'h11, 8'h22, 8'h22, 8'h82};
        send_q();
        tick(20);
        expect_writes("wrap", base, 15'h7FFF, 16'h1111, 15'h0000, 16'h2222);
        expect_status("wrap", 1'b1, 1'b0, 16'd2);

        base = wr_total;
        tx_q = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        send_q();
        tick(20);
        check_eq("zero_nwr", wr_total - base, 32'd0);
        expect_status("zero", 1'b1, 1'b0, 16'd0);

        // A 3-clock start glitch inside a frame must not produce a byte
        base = wr_total;
        tx_q = '{8'hA5, 8'h10, 8'h00};
        send_q();
        uart_rx = 1'b0;
        tick(3);
        uart_rx = 1'b1;
        tick(30);
        tx_q = '{8'h02, 8'h00, 8'h34, 8'h12, 8'hCD, 8'hAB, 8'h52};
        send_q();
        tick(20);
        expect_writes("glitch", base, 15'h0010, 16'h1234, 15'h0011, 16'hABCD);
        expect_status("glitch", 1'b1, 1'b0, 16'd2);

        tx_q = '{8'hA5, 8'h10, 8'h00};
        send_q();
        send_byte(8'h02, 1'b0);
        tick(20);
        expect_status("stop0", 1'b0, 1'b1, 16'd0);
        good_frame("after_stop0");

        tx_q = '{8'hA5, 8'h10, 8'h00};
        send_q();
        tick(250);
        expect_status("timeout", 1'b0, 1'b1, 16'd0);

        // Reset after the first word: outputs clear without a clock edge
        tx_q = '{8'hA5, 8'h10, 8'h00, 8'h02, 8'h00, 8'h34, 8'h12};
        send_q();
        tick(5);
        check_eq("pre_rst_words", {16'd0, words_loaded}, 32'd1);
        #2 init_n = 1'b0;
        #1;
        check_eq("async_busy",  {31'd0, busy}, 32'd0);
        check_eq("async_words", {16'd0, words_loaded}, 32'd0);
        check_eq("async_addr",  {17'd0, u_if.pram_address}, 32'd0);
        check_eq("async_data",  {16'd0, u_if.pram_data}, 32'd0);
        check_eq("async_wren",  {31'd0, u_if.pram_wren}, 32'd0);
        tick(2);
        init_n = 1'b1;
        tick(5);
        good_frame("after_rst");

        check_eq("wren_width", wide_cnt, 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
